// File: rtl/idex_pipe_if.sv
// Bundle channel between decode, the ID/EX boundary register and execute.
// The slave modport is the pipeline stage; the master modport is its environment.
interface idex_pipe_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  ers1_i;
  logic                  ers2_i;
  logic [2:0]            specinst_i;
  logic [3:0]            aluop_i;
  logic [4:0]            rd_i;
  logic [DATA_WIDTH-1:0] rs1_i;
  logic [DATA_WIDTH-1:0] rs2_i;
  logic [DATA_WIDTH-1:0] pc_i;
  logic [DATA_WIDTH-1:0] imme_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic                  ers1_o;
  logic                  ers2_o;
  logic [2:0]            specinst_o;
  logic [3:0]            aluop_o;
  logic [4:0]            rd_o;
  logic [DATA_WIDTH-1:0] rs1_o;
  logic [DATA_WIDTH-1:0] rs2_o;
  logic [DATA_WIDTH-1:0] pc_o;
  logic [DATA_WIDTH-1:0] imme_o;
  logic                  flush_i;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;

  modport slave (
    input  in_valid_i, ers1_i, ers2_i, specinst_i, aluop_i, rd_i,
           rs1_i, rs2_i, pc_i, imme_i, out_ready_i, flush_i,
    output in_ready_o, out_valid_o, ers1_o, ers2_o, specinst_o, aluop_o,
           rd_o, rs1_o, rs2_o, pc_o, imme_o, stall_cnt_o
  );

  modport master (
    output in_valid_i, ers1_i, ers2_i, specinst_i, aluop_i, rd_i,
           rs1_i, rs2_i, pc_i, imme_i, out_ready_i, flush_i,
    input  in_ready_o, out_valid_o, ers1_o, ers2_o, specinst_o, aluop_o,
           rd_o, rs1_o, rs2_o, pc_o, imme_o, stall_cnt_o
  );
endinterface

// File: rtl/idex_pipe.sv
// ID->EX pipeline boundary: two-entry skid buffer with registered ready,
// synchronous redirect flush and a saturating back-pressure counter.
module idex_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input logic         clk,
  input logic         rst_n,
  idex_pipe_if.slave  bus
);
  localparam int BW = 2 + 3 + 4 + 5 + 4 * DATA_WIDTH;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]           r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [BW-1:0]        r_main;
  logic [BW-1:0]        r_skid;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  logic [BW-1:0]        w_in_bundle;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic [1:0]           w_state_nxt;
  logic                 w_load_main_in;
  logic                 w_load_main_skid;
  logic                 w_load_skid;

  assign w_in_bundle = {bus.ers1_i, bus.ers2_i, bus.specinst_i, bus.aluop_i, bus.rd_i,
                        bus.rs1_i, bus.rs2_i, bus.pc_i, bus.imme_i};
  assign w_in_fire   = bus.in_valid_i && r_in_ready;
  assign w_out_fire  = r_out_valid && bus.out_ready_i;

  assign bus.in_ready_o  = r_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.stall_cnt_o = r_stall_cnt;
  assign {bus.ers1_o, bus.ers2_o, bus.specinst_o, bus.aluop_o, bus.rd_o,
          bus.rs1_o, bus.rs2_o, bus.pc_o, bus.imme_o} = r_main;

  // Next state and payload moves; flush overrides every fire.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (bus.flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt    = S_ONE;
            w_load_main_in = 1'b1;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_state_nxt    = S_ONE;
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = S_FULL;
            w_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end else begin
            w_state_nxt = S_ONE;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt      = S_ONE;
            w_load_main_skid = 1'b1;
          end else begin
            w_state_nxt = S_FULL;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // Control state; ready/valid are registered copies of the next state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  // Payload storage; stale contents survive a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= {BW{1'b0}};
      r_skid <= {BW{1'b0}};
    end else begin
      if (w_load_main_in) begin
        r_main <= w_in_bundle;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_bundle;
      end
    end
  end

  // Saturating stall counter, counts through flush cycles too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_WIDTH{1'b0}};
    end else if (r_out_valid && !bus.out_ready_i && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_idex_pipe.sv
// Directed bench for idex_pipe: per-cycle vector table for handshake/flush
// behaviour, plus sequences for field pass-through, counter saturation and async reset.
module tb_idex_pipe;
  logic clk;
  logic rst_n;
  logic rst_n_b;

  idex_pipe_if #(.DATA_WIDTH(64), .CNT_WIDTH(32)) bus ();
  idex_pipe_if #(.DATA_WIDTH(64), .CNT_WIDTH(4))  sbus ();

  idex_pipe #(.DATA_WIDTH(64), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  idex_pipe #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut_s (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (sbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        rdy;
    logic        fl;
    logic [63:0] pc;
    logic        e_ov;
    logic        e_ir;
    logic [63:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tab[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic rdy, input logic fl, input logic [63:0] pc,
                     input logic e_ov, input logic e_ir, input logic [63:0] e_pc,
                     input logic [31:0] e_cnt);
    vec_t t;
    t.v = v; t.rdy = rdy; t.fl = fl; t.pc = pc;
    t.e_ov = e_ov; t.e_ir = e_ir; t.e_pc = e_pc; t.e_cnt = e_cnt;
    tab.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_n_b = 1'b0;
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0; bus.flush_i = 1'b0;
    bus.ers1_i = 1'b0; bus.ers2_i = 1'b0; bus.specinst_i = 3'd0; bus.aluop_i = 4'd0;
    bus.rd_i = 5'd0; bus.rs1_i = 64'd0; bus.rs2_i = 64'd0; bus.pc_i = 64'd0; bus.imme_i = 64'd0;
    sbus.in_valid_i = 1'b0; sbus.out_ready_i = 1'b0; sbus.flush_i = 1'b0;
    sbus.ers1_i = 1'b0; sbus.ers2_i = 1'b0; sbus.specinst_i = 3'd0; sbus.aluop_i = 4'd0;
    sbus.rd_i = 5'd0; sbus.rs1_i = 64'd0; sbus.rs2_i = 64'd0; sbus.pc_i = 64'd0; sbus.imme_i = 64'd0;

    // Streaming: every bundle visible one edge after acceptance.
    for (int i = 0; i < 8; i++) begin
      add(1'b1, 1'b1, 1'b0, 64'h1000 + 64'(4 * i), 1'b1, 1'b1, 64'h1000 + 64'(4 * i), 32'd0);
    end
    add(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0, 32'd0);
    // Back-pressure into the skid, then drain in order.
    add(1'b1, 1'b0, 1'b0, 64'h2000, 1'b1, 1'b1, 64'h2000, 32'd0);
    add(1'b1, 1'b0, 1'b0, 64'h2004, 1'b1, 1'b0, 64'h2000, 32'd1);
    add(1'b1, 1'b0, 1'b0, 64'h2008, 1'b1, 1'b0, 64'h2000, 32'd2);
    add(1'b1, 1'b1, 1'b0, 64'h2008, 1'b1, 1'b1, 64'h2004, 32'd2);
    add(1'b1, 1'b1, 1'b0, 64'h2008, 1'b1, 1'b1, 64'h2008, 32'd2);
    add(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0, 32'd2);
    // Flush while FULL drops everything, including offered 0x3000.
    add(1'b1, 1'b0, 1'b0, 64'h2ff0, 1'b1, 1'b1, 64'h2ff0, 32'd2);
    add(1'b1, 1'b0, 1'b0, 64'h2ff4, 1'b1, 1'b0, 64'h2ff0, 32'd3);
    add(1'b1, 1'b0, 1'b1, 64'h3000, 1'b0, 1'b1, 64'h0, 32'd4);
    // Flush in ONE with in_ready high: offered bundle still dropped.
    add(1'b1, 1'b1, 1'b0, 64'h3100, 1'b1, 1'b1, 64'h3100, 32'd4);
    add(1'b1, 1'b1, 1'b1, 64'h3104, 1'b0, 1'b1, 64'h0, 32'd4);
    add(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0, 32'd4);
    // Simultaneous in/out fire while ONE.
    add(1'b1, 1'b0, 1'b0, 64'h4000, 1'b1, 1'b1, 64'h4000, 32'd4);
    add(1'b1, 1'b1, 1'b0, 64'h4004, 1'b1, 1'b1, 64'h4004, 32'd4);
    add(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h4004, 32'd5);
    add(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0, 32'd5);

    #12;
    chk("reset out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("reset pc", bus.pc_o, 64'd0);
    chk("reset imme", bus.imme_o, 64'd0);
    chk("reset fields", 64'({bus.ers1_o, bus.ers2_o, bus.specinst_o, bus.aluop_o, bus.rd_o}), 64'd0);
    chk("reset rs", bus.rs1_o | bus.rs2_o, 64'd0);
    chk("reset cnt", 64'(bus.stall_cnt_o), 64'd0);
    #10;
    rst_n   = 1'b1;
    rst_n_b = 1'b1;

    foreach (tab[k]) begin
      bus.in_valid_i  = tab[k].v;
      bus.out_ready_i = tab[k].rdy;
      bus.flush_i     = tab[k].fl;
      bus.pc_i        = tab[k].pc;
      tick();
      chk($sformatf("v%0d out_valid", k), 64'(bus.out_valid_o), 64'(tab[k].e_ov));
      chk($sformatf("v%0d in_ready", k), 64'(bus.in_ready_o), 64'(tab[k].e_ir));
      chk($sformatf("v%0d stall_cnt", k), 64'(bus.stall_cnt_o), 64'(tab[k].e_cnt));
      if (tab[k].e_ov) begin
        chk($sformatf("v%0d pc", k), bus.pc_o, tab[k].e_pc);
      end
    end

    // Field pass-through.
    bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1; bus.flush_i = 1'b0;
    bus.ers1_i = 1'b0; bus.ers2_i = 1'b1; bus.specinst_i = 3'd5; bus.aluop_i = 4'hF;
    bus.rd_i = 5'd31; bus.rs1_i = 64'h0123_4567_89AB_CDEF; bus.rs2_i = 64'hFEDC_BA98_7654_3210;
    bus.pc_i = 64'h5550; bus.imme_i = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    bus.in_valid_i = 1'b0;
    chk("pt ers1", 64'(bus.ers1_o), 64'd0);
    chk("pt ers2", 64'(bus.ers2_o), 64'd1);
    chk("pt specinst", 64'(bus.specinst_o), 64'd5);
    chk("pt aluop", 64'(bus.aluop_o), 64'hF);
    chk("pt rd", 64'(bus.rd_o), 64'd31);
    chk("pt rs1", bus.rs1_o, 64'h0123_4567_89AB_CDEF);
    chk("pt rs2", bus.rs2_o, 64'hFEDC_BA98_7654_3210);
    chk("pt pc", bus.pc_o, 64'h5550);
    chk("pt imme", bus.imme_o, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    chk("pt drained", 64'(bus.out_valid_o), 64'd0);

    // Saturation on the 4-bit counter instance.
    sbus.in_valid_i = 1'b1; sbus.pc_i = 64'h6000; sbus.out_ready_i = 1'b0;
    tick();
    sbus.in_valid_i = 1'b0;
    chk("sat loaded", 64'(sbus.out_valid_o), 64'd1);
    chk("sat cnt0", 64'(sbus.stall_cnt_o), 64'd0);
    for (int i = 0; i < 14; i++) tick();
    chk("sat cnt14", 64'(sbus.stall_cnt_o), 64'hE);
    for (int i = 0; i < 6; i++) tick();
    chk("sat cnt sticks", 64'(sbus.stall_cnt_o), 64'hF);
    chk("sat pc stable", sbus.pc_o, 64'h6000);

    // Asynchronous reset mid-stall, checked before any further clock edge.
    #2;
    rst_n_b = 1'b0;
    #1;
    chk("arst out_valid", 64'(sbus.out_valid_o), 64'd0);
    chk("arst in_ready", 64'(sbus.in_ready_o), 64'd1);
    chk("arst pc", sbus.pc_o, 64'd0);
    chk("arst cnt", 64'(sbus.stall_cnt_o), 64'd0);
    #1;
    rst_n_b = 1'b1;
    tick();
    chk("arst stays empty", 64'(sbus.out_valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
